// File: rtl/music_pkg.sv
// Shared note codes, FSM state encoding, ROM entry layout and built-in melody for the note sequencer.
package music_pkg;

  localparam int DEFAULT_TICK_DIV = 6250000;

  localparam logic [2:0] NOTE_A4   = 3'd0;
  localparam logic [2:0] NOTE_B4   = 3'd1;
  localparam logic [2:0] NOTE_C5   = 3'd2;
  localparam logic [2:0] NOTE_D5   = 3'd3;
  localparam logic [2:0] NOTE_E5   = 3'd4;
  localparam logic [2:0] NOTE_F5   = 3'd5;
  localparam logic [2:0] NOTE_G5   = 3'd6;
  localparam logic [2:0] NOTE_REST = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_PLAY   = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  // ROM word layout: {note, dur}, dur in tempo ticks, dur==0 marks end-of-song.
  typedef struct packed {
    logic [2:0] note;
    logic [3:0] dur;
  } rom_entry_t;

  function automatic rom_entry_t default_song(input int idx);
    rom_entry_t e;
    e = '0;
    case (idx)
      0, 1:    e = '{note: NOTE_A4,   dur: 4'd2};
      2, 3:    e = '{note: NOTE_B4,   dur: 4'd2};
      4, 5:    e = '{note: NOTE_C5,   dur: 4'd2};
      6:       e = '{note: NOTE_B4,   dur: 4'd4};
      7:       e = '{note: NOTE_REST, dur: 4'd1};
      8, 9:    e = '{note: NOTE_G5,   dur: 4'd2};
      10, 11:  e = '{note: NOTE_F5,   dur: 4'd2};
      12:      e = '{note: NOTE_E5,   dur: 4'd2};
      13:      e = '{note: NOTE_D5,   dur: 4'd2};
      14:      e = '{note: NOTE_A4,   dur: 4'd4};
      default: e = '{note: NOTE_REST, dur: 4'd0};
    endcase
    return e;
  endfunction

endpackage

// File: rtl/song_rom.sv
// Combinational melody ROM indexed by step; returns {note, dur} from the built-in song
// or from a packed ROM_INIT image when USE_INIT is set.
module song_rom
  import music_pkg::*;
#(
  parameter int SONG_LEN = 16,
  parameter int NOTE_W   = 3,
  parameter int DUR_W    = 4,
  parameter int STEP_W   = 4,
  parameter bit USE_INIT = 1'b0,
  parameter logic [SONG_LEN*(NOTE_W+DUR_W)-1:0] ROM_INIT = '0
) (
  input  logic [STEP_W-1:0] i_step,
  output logic [NOTE_W-1:0] o_note,
  output logic [DUR_W-1:0]  o_dur
);

  localparam int EW = NOTE_W + DUR_W;

  logic [EW-1:0] w_entry;
  rom_entry_t    w_def;

  always_comb begin
    w_entry = '0;
    w_def   = '0;
    for (int k = 0; k < SONG_LEN; k++) begin
      if (STEP_W'(k) == i_step) begin
        if (USE_INIT) begin
          w_entry = ROM_INIT[k*EW +: EW];
        end else begin
          w_def   = default_song(k);
          w_entry = {NOTE_W'(w_def.note), DUR_W'(w_def.dur)};
        end
      end
    end
  end

  assign o_note = w_entry[EW-1 -: NOTE_W];
  assign o_dur  = w_entry[DUR_W-1:0];

endmodule

// File: rtl/note_sequencer.sv
// Steps through the melody ROM and drives the tone generator's note select; each note is held
// for dur tempo ticks. Define SONG_LOOP_EN to restart the song after end-of-song instead of idling.
module note_sequencer
  import music_pkg::*;
#(
  parameter int CLK_HZ       = 50000000,
  parameter int TICK_DIV     = DEFAULT_TICK_DIV,
  parameter int SONG_LEN     = 16,
  parameter int NOTE_W       = 3,
  parameter int DUR_W        = 4,
  parameter bit USE_ROM_INIT = 1'b0,
  parameter logic [SONG_LEN*(NOTE_W+DUR_W)-1:0] ROM_INIT = '0,
  localparam int STEP_W      = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1
) (
  input  logic              externalClock,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  output logic [NOTE_W-1:0] note,
  output logic              sound_en,
  output logic              busy,
  output logic [STEP_W-1:0] step,
  output logic              done
);

  // A tempo tick is never allowed to be slower than one second.
  localparam int TICK_DIV_EFF = (TICK_DIV > CLK_HZ) ? CLK_HZ : TICK_DIV;
  localparam int TW           = (TICK_DIV_EFF > 1) ? $clog2(TICK_DIV_EFF) : 1;

  state_t            r_state, w_state_nxt;
  logic [STEP_W-1:0] r_step, w_step_nxt;
  logic [TW-1:0]     r_tick_cnt, w_tick_nxt;
  logic [DUR_W-1:0]  r_dur_cnt, w_dur_nxt;
  logic [NOTE_W-1:0] r_note, w_note_nxt;
  logic              r_sound_en, w_snd_nxt;
  logic              r_done, w_done_nxt;

  logic [NOTE_W-1:0] w_rom_note;
  logic [DUR_W-1:0]  w_rom_dur;
  logic              w_tick;

  song_rom #(
    .SONG_LEN (SONG_LEN),
    .NOTE_W   (NOTE_W),
    .DUR_W    (DUR_W),
    .STEP_W   (STEP_W),
    .USE_INIT (USE_ROM_INIT),
    .ROM_INIT (ROM_INIT)
  ) u_rom (
    .i_step (r_step),
    .o_note (w_rom_note),
    .o_dur  (w_rom_dur)
  );

  assign w_tick = (r_tick_cnt == TW'(TICK_DIV_EFF - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    w_tick_nxt  = r_tick_cnt;
    w_dur_nxt   = r_dur_cnt;
    w_note_nxt  = r_note;
    w_snd_nxt   = r_sound_en;
    w_done_nxt  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start && !stop) begin
          w_state_nxt = ST_LOAD;
          w_step_nxt  = '0;
        end
      end
      ST_LOAD: begin
        if (w_rom_dur == '0) begin
          w_state_nxt = ST_FINISH;
          w_note_nxt  = '0;
          w_snd_nxt   = 1'b0;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = ST_PLAY;
          w_note_nxt  = w_rom_note;
          w_snd_nxt   = (w_rom_note != NOTE_W'(NOTE_REST));
          w_dur_nxt   = w_rom_dur;
          w_tick_nxt  = '0;
        end
      end
      ST_PLAY: begin
        if (w_tick) begin
          w_tick_nxt = '0;
          w_dur_nxt  = r_dur_cnt - DUR_W'(1);
          if (r_dur_cnt == DUR_W'(1)) begin
            // The last ROM entry expiring ends the song; step never wraps back to 0 here.
            if (r_step == STEP_W'(SONG_LEN - 1)) begin
              w_state_nxt = ST_FINISH;
              w_note_nxt  = '0;
              w_snd_nxt   = 1'b0;
              w_done_nxt  = 1'b1;
            end else begin
              w_state_nxt = ST_LOAD;
              w_step_nxt  = r_step + STEP_W'(1);
            end
          end
        end else begin
          w_tick_nxt = r_tick_cnt + TW'(1);
        end
      end
      ST_FINISH: begin
`ifdef SONG_LOOP_EN
        w_state_nxt = ST_LOAD;
        w_step_nxt  = '0;
`else
        w_state_nxt = ST_IDLE;
`endif
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // stop overrides everything, including a note expiring in the same cycle.
    if (stop && (r_state != ST_IDLE)) begin
      w_state_nxt = ST_IDLE;
      w_step_nxt  = '0;
      w_note_nxt  = '0;
      w_snd_nxt   = 1'b0;
      w_done_nxt  = 1'b0;
    end
  end

  always_ff @(posedge externalClock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_step     <= '0;
      r_tick_cnt <= '0;
      r_dur_cnt  <= '0;
      r_note     <= '0;
      r_sound_en <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_step     <= w_step_nxt;
      r_tick_cnt <= w_tick_nxt;
      r_dur_cnt  <= w_dur_nxt;
      r_note     <= w_note_nxt;
      r_sound_en <= w_snd_nxt;
      r_done     <= w_done_nxt;
    end
  end

  assign note     = r_note;
  assign sound_en = r_sound_en;
  assign busy     = (r_state != ST_IDLE);
  assign step     = r_step;
  assign done     = r_done;

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer: stimulus pushes per-cycle expected outputs, a negedge monitor pops and compares.
module tb_note_sequencer;

  typedef struct packed {
    logic       busy;
    logic [2:0] note;
    logic       snd;
    logic [1:0] step;
    logic       done;
  } obs_t;

  typedef struct packed {
    logic which;
    obs_t o;
  } sb_t;

  // Entries are {note, dur}; entry 0 in the low bits.
  localparam logic [27:0] ROM_NOM  = {7'b000_0000, 7'b001_0011, 7'b111_0001, 7'b000_0010};
  localparam logic [27:0] ROM_FULL = {7'b011_0001, 7'b010_0001, 7'b001_0001, 7'b000_0001};

  logic       clk = 1'b0;
  logic       rst, start_a, start_b, stop;
  logic [2:0] note_a, note_b;
  logic       snd_a, snd_b, busy_a, busy_b, done_a, done_b;
  logic [1:0] step_a, step_b;
  obs_t       obs_a, obs_b;

  sb_t   sb[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  bit    fin = 1'b0;
  bit    cur_dut = 1'b0;
  string phase = "init";

  always #5 clk = ~clk;

  note_sequencer #(.TICK_DIV(4), .SONG_LEN(4), .USE_ROM_INIT(1'b1), .ROM_INIT(ROM_NOM)) u_dut_a (
    .externalClock (clk), .reset (rst), .start (start_a), .stop (stop),
    .note (note_a), .sound_en (snd_a), .busy (busy_a), .step (step_a), .done (done_a)
  );

  note_sequencer #(.TICK_DIV(4), .SONG_LEN(4), .USE_ROM_INIT(1'b1), .ROM_INIT(ROM_FULL)) u_dut_b (
    .externalClock (clk), .reset (rst), .start (start_b), .stop (stop),
    .note (note_b), .sound_en (snd_b), .busy (busy_b), .step (step_b), .done (done_b)
  );

  assign obs_a = {busy_a, note_a, snd_a, step_a, done_a};
  assign obs_b = {busy_b, note_b, snd_b, step_b, done_b};

  function automatic obs_t mk(input bit b, input int n, input bit s, input int st, input bit d);
    mk = {b, 3'(n), s, 2'(st), d};
  endfunction

  function automatic int nseg(input bit full);
    return full ? 10 : 9;
  endfunction

  function automatic int seg_len(input bit full, input int s);
    if (full) begin
      case (s)
        1, 3, 5, 7: return 4;
        default:    return 1;
      endcase
    end else begin
      case (s)
        1:       return 8;
        3:       return 4;
        5:       return 12;
        default: return 1;
      endcase
    end
  endfunction

  // Expected per-cycle outputs from the first LOAD cycle through one IDLE cycle after done.
  function automatic obs_t seg_obs(input bit full, input int s);
    if (full) begin
      case (s)
        0:       return mk(1, 0, 0, 0, 0);
        1:       return mk(1, 0, 1, 0, 0);
        2:       return mk(1, 0, 1, 1, 0);
        3:       return mk(1, 1, 1, 1, 0);
        4:       return mk(1, 1, 1, 2, 0);
        5:       return mk(1, 2, 1, 2, 0);
        6:       return mk(1, 2, 1, 3, 0);
        7:       return mk(1, 3, 1, 3, 0);
        8:       return mk(1, 0, 0, 3, 1);
        default: return mk(0, 0, 0, 3, 0);
      endcase
    end else begin
      case (s)
        0:       return mk(1, 0, 0, 0, 0);
        1:       return mk(1, 0, 1, 0, 0);
        2:       return mk(1, 0, 1, 1, 0);
        3:       return mk(1, 7, 0, 1, 0);
        4:       return mk(1, 7, 0, 2, 0);
        5:       return mk(1, 1, 1, 2, 0);
        6:       return mk(1, 1, 1, 3, 0);
        7:       return mk(1, 0, 0, 3, 1);
        default: return mk(0, 0, 0, 3, 0);
      endcase
    end
  endfunction

  task automatic push_exp(input obs_t e);
    sb_t ent;
    ent.which = cur_dut;
    ent.o     = e;
    sb.push_back(ent);
  endtask

  task automatic expect_n(input int n, input obs_t e);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
      start_a = 1'b0;
      start_b = 1'b0;
      stop    = 1'b0;
      push_exp(e);
    end
  endtask

  task automatic run_song(input bit full, input int limit, input int poke_at);
    int c;
    c = 0;
    for (int s = 0; s < nseg(full); s++) begin
      for (int k = 0; k < seg_len(full, s); k++) begin
        if (c < limit) begin
          if (c == poke_at) begin
            if (full) start_b = 1'b1;
            else      start_a = 1'b1;
          end
          expect_n(1, seg_obs(full, s));
          c++;
        end
      end
    end
  endtask

  initial begin
    sb_t  ent;
    obs_t act;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        ent = sb.pop_front();
        act = ent.which ? obs_b : obs_a;
        n_cmp++;
        if (act !== ent.o) begin
          n_bad++;
          $display("FAIL %s: got busy=%0b note=%0d snd=%0b step=%0d done=%0b, expected busy=%0b note=%0d snd=%0b step=%0d done=%0b",
                   phase, act.busy, act.note, act.snd, act.step, act.done,
                   ent.o.busy, ent.o.note, ent.o.snd, ent.o.step, ent.o.done);
        end
      end
      if (fin) begin
        n_cmp++;
        if (sb.size() != 0) begin
          n_bad++;
          $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst     = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    stop    = 1'b0;

    phase = "reset";
    expect_n(2, '0);
    rst = 1'b0;
    expect_n(2, '0);

`ifdef SONG_LOOP_EN
    phase = "loop";
    start_a = 1'b1;
    for (int r = 0; r < 3; r++) run_song(1'b0, 29, -1);
    stop = 1'b1;
    expect_n(3, '0);
`else
    phase = "nominal";
    start_a = 1'b1;
    run_song(1'b0, 30, -1);

    phase = "abort";
    start_a = 1'b1;
    run_song(1'b0, 20, -1);
    stop = 1'b1;
    expect_n(3, '0);

    phase = "stop_start";
    start_a = 1'b1;
    run_song(1'b0, 5, -1);
    start_a = 1'b1;
    stop    = 1'b1;
    expect_n(1, '0);
    start_a = 1'b1;
    stop    = 1'b1;
    expect_n(2, '0);

    phase = "busy_start";
    start_a = 1'b1;
    run_song(1'b0, 30, 11);

    phase = "reset_mid";
    start_a = 1'b1;
    run_song(1'b0, 20, -1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    push_exp('0);
    expect_n(1, '0);
    rst = 1'b0;
    expect_n(1, '0);

    phase = "replay";
    start_a = 1'b1;
    run_song(1'b0, 30, -1);

    phase = "full_rom";
    cur_dut = 1'b1;
    start_b = 1'b1;
    run_song(1'b1, 100, -1);
`endif

    @(posedge clk);
    #2;
    fin = 1'b1;
  end

endmodule
